cam_dvp_source: RTL and testbench

- Synthesizable OV7670-style DVP pixel-stream transmitter. It is the far end of the camera capture interface: it drives pclk, vsync, href and 8-bit pixel data exactly as the sensor does.
- Used for loopback bring-up of the camera capture path on the Nexys A7 without a physical sensor. The same block doubles as the stimulus source in the capture-path testbenches.
- Emits RGB565 frames (high byte first) from a selectable test pattern.

---
 rtl/cam_dvp_source.sv | 140 ++++++++++++++
 tb/tb_cam_dvp_source.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_dvp_source.sv
// cam_dvp_source: OV7670-style DVP transmitter emitting RGB565 test-pattern frames
// Ports:
//   clk, rstn             - system clock, synchronous active-low reset
//   i_en                  - start / continue frame generation
//   i_mode                - pattern: 0 colour bars, 1 byte ramp, 2/3 solid i_color
//   i_color               - RGB565 colour for solid mode
//   o_pclk                - free-running pixel clock, clk / PCLK_DIV
//   o_vsync/o_href/o_data - DVP sync and byte bus, updated on the pclk falling edge
//   o_frame_done          - one-clk pulse at the end of each frame
//   o_busy                - high while a frame is in progress
module cam_dvp_source #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP         = 17,
    parameter int VFP         = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_en,
    input  logic [1:0]  i_mode,
    input  logic [15:0] i_color,
    output logic        o_pclk,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_frame_done,
    output logic        o_busy
);
    localparam int LINE = 2 * H_ACTIVE + H_BLANK;
    localparam int CW   = $clog2(LINE);
    localparam int ML1  = VSYNC_LINES > VBP ? VSYNC_LINES : VBP;
    localparam int ML2  = V_ACTIVE > VFP ? V_ACTIVE : VFP;
    localparam int MAXL = ML1 > ML2 ? ML1 : ML2;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int PW   = $clog2(PCLK_DIV);
    localparam int BPB  = H_ACTIVE / 4;
    localparam int BW   = $clog2(BPB);
    localparam logic [PW-1:0] PH_LAST   = PW'(PCLK_DIV - 1);
    localparam logic [PW-1:0] PH_HI     = PW'(PCLK_DIV / 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(LINE - 1);
    localparam logic [CW-1:0] COL_ACT   = CW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BPB - 1);
    localparam logic [LW-1:0] L_VS      = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_VBP     = LW'(VBP - 1);
    localparam logic [LW-1:0] L_ACT     = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] L_VFP     = LW'(VFP - 1);
    localparam logic [15:0]   BARS [8]  = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [2:0] {IDLE, VSYNC, VBP_S, ACTIVE, VFP_S} state_t;

    state_t        state_q, state_d, state_n;
    logic [PW-1:0] ph_q, ph_d;
    logic          pclk_q, pclk_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d, line_lst;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   color_q, color_d, bar_c;
    logic          vsync_q, vsync_d, href_q, href_d, done_q, done_d, busy_q, busy_d;
    logic [7:0]    data_q, data_d, pix;
    logic          tick, line_end, last, idle, start, bar_wrap, act;

    // Counters describe the pclk period being driven; on a tick the next
    // position is computed and the outputs are registered from it, so the bus
    // changes on the pclk falling edge and is stable across the rising edge.
    // Off-tick the next position equals the current one, so the outputs hold.
    always_comb begin
        tick     = ph_q == PH_LAST;
        ph_d     = tick ? '0 : ph_q + 1'b1;
        pclk_d   = ph_d >= PH_HI;
        line_end = col_q == COL_LAST;
        line_lst = state_q == VSYNC ? L_VS : state_q == VBP_S ? L_VBP : state_q == ACTIVE ? L_ACT : L_VFP;
        last     = line_end && line_q == line_lst;
        idle     = state_q == IDLE;
        start    = tick && i_en && (idle || (state_q == VFP_S && last));
        bar_wrap = bcnt_q == BCNT_LAST;
        state_n  = state_q == VSYNC ? VBP_S : state_q == VBP_S ? ACTIVE : state_q == ACTIVE ? VFP_S : (i_en ? VSYNC : IDLE);
        state_d  = !tick ? state_q : idle ? (i_en ? VSYNC : IDLE) : last ? state_n : state_q;
        col_d    = !tick ? col_q : (idle || line_end) ? '0 : col_q + 1'b1;
        line_d   = !tick ? line_q : (idle || last) ? '0 : line_end ? line_q + 1'b1 : line_q;
        bcnt_d   = !tick ? bcnt_q : (idle || line_end || bar_wrap) ? '0 : bcnt_q + 1'b1;
        bar_d    = !tick ? bar_q : (idle || line_end) ? '0 : bar_wrap ? bar_q + 1'b1 : bar_q;
        mode_d   = start ? i_mode : mode_q;
        color_d  = start ? i_color : color_q;
        act      = state_d == ACTIVE && col_d < COL_ACT;
        bar_c    = mode_q == 2'd0 ? BARS[bar_d] : color_q;
        pix      = mode_q == 2'd1 ? 8'(col_d) : col_d[0] ? bar_c[7:0] : bar_c[15:8];
        vsync_d  = state_d == VSYNC;
        href_d   = act;
        data_d   = act ? pix : 8'h00;
        done_d   = tick && state_q == VFP_S && last;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ph_q    <= '0;
            pclk_q  <= 1'b0;
            col_q   <= '0;
            line_q  <= '0;
            bcnt_q  <= '0;
            bar_q   <= '0;
            mode_q  <= '0;
            color_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pclk_q  <= pclk_d;
            col_q   <= col_d;
            line_q  <= line_d;
            bcnt_q  <= bcnt_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_pclk       = pclk_q;
    assign o_vsync      = vsync_q;
    assign o_href       = href_q;
    assign o_data       = data_q;
    assign o_frame_done = done_q;
    assign o_busy       = busy_q;
endmodule

// File: tb/tb_cam_dvp_source.sv
// tb_cam_dvp_source: self-checking bench for cam_dvp_source with a byte scoreboard
module tb_cam_dvp_source;
    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 4;
    localparam int LB       = 2 * H_ACTIVE;

    logic        clk = 1'b0;
    logic        rstn, i_en;
    logic [1:0]  i_mode;
    logic [15:0] i_color;
    logic        o_pclk, o_vsync, o_href, o_frame_done, o_busy;
    logic [7:0]  o_data;

    cam_dvp_source #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(4),
        .VSYNC_LINES(2), .VBP(1), .VFP(1), .PCLK_DIV(2)
    ) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_mode(i_mode), .i_color(i_color),
        .o_pclk(o_pclk), .o_vsync(o_vsync), .o_href(o_href), .o_data(o_data),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] color;
        logic [7:0]  b0, b5, b13, b30;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] exp_q [$];
    logic [7:0] line0 [LB];
    int checks = 0, passed = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, vs_rises = 0, vs_rise_cyc = 0, busy0 = 0;
    int pn = 0, vs_run = 0, vs_len = 0, vs_last_p = 0, first_href_p = -1;
    int hr_run = 0, href_runs = 0, fb = 0;
    bit pclk_prev = 0, vs_prev = 0, href_prev = 0, vs_clk_prev = 0, done_prev = 0;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input logic [1:0] m, input logic [15:0] c, input int idx);
        logic [15:0] w;
        if (m == 2'd1) return idx[7:0];
        w = (m == 2'd0) ? bars[idx / (H_ACTIVE / 4)] : c;
        return idx[0] ? w[7:0] : w[15:8];
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [15:0] c);
        for (int l = 0; l < V_ACTIVE; l++)
            for (int b = 0; b < LB; b++) exp_q.push_back(exp_byte(m, c, b));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_vs(input int budget);
        int r, i;
        r = vs_rises;
        i = 0;
        while (vs_rises == r && i < budget) begin
            step(1);
            i++;
        end
        chk("vsync_start_seen", int'(vs_rises != r), 1);
    endtask

    task automatic wait_done(input int budget);
        int r, i;
        r = done_cnt;
        i = 0;
        while (done_cnt == r && i < budget) begin
            step(1);
            i++;
        end
        chk("frame_done_seen", int'(done_cnt != r), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pclk"}, o_pclk, 0);
        chk({tag, "_vsync"}, o_vsync, 0);
        chk({tag, "_href"}, o_href, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_frame_done, 0);
    endtask

    // Monitor: clk-level event timing plus one sample per pclk rising edge.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!o_busy) busy0++;
            if (o_frame_done && !done_prev) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_vsync && !vs_clk_prev) begin
                vs_rises++;
                vs_rise_cyc = cyc;
            end
            done_prev = o_frame_done;
            vs_clk_prev = o_vsync;
            if (o_pclk && !pclk_prev) begin
                pn++;
                if (o_vsync && !vs_prev) begin
                    vs_run = 0;
                    fb = 0;
                    href_runs = 0;
                    first_href_p = -1;
                end
                if (o_vsync) begin
                    vs_run++;
                    vs_last_p = pn;
                end
                if (!o_vsync && vs_prev) vs_len = vs_run;
                if (o_href) begin
                    if (first_href_p < 0) first_href_p = pn;
                    hr_run++;
                    if (fb < LB) line0[fb] = o_data;
                    fb++;
                    e = exp_q.size() > 0 ? int'(exp_q.pop_front()) : 256;
                    chk("sb_byte", o_data, e);
                end else if (href_prev) begin
                    chk("href_len", hr_run, LB);
                    href_runs++;
                    hr_run = 0;
                end
                vs_prev = o_vsync;
                href_prev = o_href;
            end
            pclk_prev = o_pclk;
        end
    end

    initial begin
        int tog, d0, b0, r;
        bit pp, any;
        tbl[0] = '{2'd1, 16'h0000, 8'h00, 8'h05, 8'h0D, 8'h1E};
        tbl[1] = '{2'd0, 16'h0000, 8'hFF, 8'hE0, 8'hE0, 8'h00};
        tbl[2] = '{2'd2, 16'h1234, 8'h12, 8'h34, 8'h34, 8'h12};
        tbl[3] = '{2'd3, 16'hBEEF, 8'hBE, 8'hEF, 8'hEF, 8'hBE};
        tbl[4] = '{2'd0, 16'h5555, 8'hFF, 8'hE0, 8'hE0, 8'h00};
        rstn = 1'b0;
        i_en = 1'b0;
        i_mode = 2'd0;
        i_color = 16'h0000;
        step(3);
        chk_reset_outputs("reset");
        rstn = 1'b1;
        pp = o_pclk;
        tog = 0;
        any = 0;
        d0 = done_cnt;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (o_pclk != pp) tog++;
            pp = o_pclk;
            any |= o_vsync | o_href | (|o_data) | o_busy;
        end
        chk("idle_pclk_toggles", tog, 100);
        chk("idle_outputs_low", any, 0);
        chk("idle_no_done", done_cnt - d0, 0);
        for (int t = 0; t < 5; t++) begin
            i_mode = tbl[t].mode;
            i_color = tbl[t].color;
            push_frame(tbl[t].mode, tbl[t].color);
            i_en = 1'b1;
            wait_vs(20);
            i_en = 1'b0;
            wait_done(700);
            chk("frame_clks", done_cyc - vs_rise_cyc, 576);
            chk("idle_busy_after_done", o_busy, 0);
            step(1);
            chk("done_width", o_frame_done, 0);
            chk("vsync_pclks", vs_len, 72);
            chk("vbp_gap", first_href_p - vs_last_p - 1, 36);
            chk("href_lines", href_runs, V_ACTIVE);
            chk("sb_empty", exp_q.size(), 0);
            chk("tbl_b0", line0[0], tbl[t].b0);
            chk("tbl_b5", line0[5], tbl[t].b5);
            chk("tbl_b13", line0[13], tbl[t].b13);
            chk("tbl_b30", line0[30], tbl[t].b30);
        end
        i_mode = 2'd0;
        push_frame(2'd0, 16'h0000);
        push_frame(2'd0, 16'h0000);
        i_en = 1'b1;
        wait_vs(20);
        b0 = busy0;
        wait_done(700);
        chk("b2b_busy_at_done", o_busy, 1);
        chk("b2b_busy_never_low", busy0 - b0, 0);
        chk("b2b_vsync_at_done", vs_rise_cyc, done_cyc);
        i_en = 1'b0;
        wait_done(700);
        chk("b2b_sb_empty", exp_q.size(), 0);
        i_mode = 2'd2;
        i_color = 16'h1234;
        push_frame(2'd2, 16'h1234);
        push_frame(2'd2, 16'hABCD);
        i_en = 1'b1;
        wait_vs(20);
        step(300);
        i_color = 16'hABCD;
        wait_done(700);
        i_en = 1'b0;
        wait_done(700);
        chk("color_next_hi", line0[0], 8'hAB);
        chk("color_next_lo", line0[1], 8'hCD);
        chk("color_sb_empty", exp_q.size(), 0);
        i_mode = 2'd1;
        push_frame(2'd1, 16'h0000);
        i_en = 1'b1;
        wait_vs(20);
        step(5 * 72 + 20);
        i_en = 1'b0;
        r = vs_rises;
        wait_done(700);
        chk("drop_busy_low", o_busy, 0);
        step(700);
        chk("drop_no_vsync", vs_rises - r, 0);
        chk("drop_still_idle", o_busy, 0);
        chk("drop_sb_empty", exp_q.size(), 0);
        push_frame(2'd1, 16'h0000);
        i_en = 1'b1;
        wait_vs(20);
        step(356);
        d0 = done_cnt;
        rstn = 1'b0;
        step(1);
        chk_reset_outputs("midrst");
        rstn = 1'b1;
        exp_q.delete();
        push_frame(2'd1, 16'h0000);
        wait_vs(20);
        chk("midrst_no_done", done_cnt - d0, 0);
        i_en = 1'b0;
        wait_done(700);
        chk("midrst_vsync_pclks", vs_len, 72);
        chk("midrst_one_done", done_cnt - d0, 1);
        chk("midrst_sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
